// File: rtl/div_issue_ctrl.sv
// EX-stage issue/retire controller for the iterative divider: launches DIV/DIVU,
// stalls the pipe until finish, writes HI/LO, and drains the divider after a flush.
module div_issue_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 36
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_div_req_i,
    input  logic        ex_div_sign_i,
    input  logic [31:0] ex_opa_i,
    input  logic [31:0] ex_opb_i,
    input  logic        flush_i,
    output logic        stall_req_o,
    output logic        div_start_o,
    output logic        div_sign_o,
    output logic [31:0] div_dividend_o,
    output logic [31:0] div_divisor_o,
    input  logic        div_finish_i,
    input  logic [63:0] div_result_i,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam int unsigned CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_start;
    logic               r_sign;
    logic [31:0]        r_dividend;
    logic [31:0]        r_divisor;
    logic               r_hilo_we;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [CNT_W-1:0]   r_drain_cnt;

    logic               w_accept;
    logic               w_stall;

    assign w_accept = ex_div_req_i & ~flush_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_start     <= 1'b0;
            r_sign      <= 1'b0;
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_hilo_we   <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_drain_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_dividend <= ex_opa_i;
                        r_divisor  <= ex_opb_i;
                        r_sign     <= ex_div_sign_i;
                        r_start    <= 1'b1;
                        r_state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Operands and sign stay put: the divider re-reads them to fix result signs.
                    if (flush_i) begin
                        r_start     <= 1'b0;
                        r_drain_cnt <= CNT_W'(DRAIN_CYCLES);
                        r_state     <= ST_DRAIN;
                    end else if (div_finish_i) begin
                        r_hi      <= div_result_i[63:32];
                        r_lo      <= div_result_i[31:0];
                        r_hilo_we <= 1'b1;
                        r_start   <= 1'b0;
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_hilo_we <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                ST_DRAIN: begin
                    // Wait out the abandoned divide before a new start can be honoured.
                    if (r_drain_cnt <= CNT_W'(1)) begin
                        r_drain_cnt <= '0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_stall = 1'b0;
        if (!flush_i) begin
            case (r_state)
                ST_IDLE:  w_stall = ex_div_req_i;
                ST_RUN:   w_stall = 1'b1;
                ST_DRAIN: w_stall = ex_div_req_i;
                default:  w_stall = 1'b0;
            endcase
        end
    end

    assign stall_req_o    = w_stall;
    assign div_start_o    = r_start;
    assign div_sign_o     = r_sign;
    assign div_dividend_o = r_dividend;
    assign div_divisor_o  = r_divisor;
    assign hilo_we_o      = r_hilo_we & ~flush_i;
    assign hi_o           = r_hi;
    assign lo_o           = r_lo;

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
EX-stage controller sitting directly upstream and downstream of the iterative divider.
- Accepts DIV/DIVU from EX and registers the operands.
- Drives the divider start/sign/operand inputs and holds the pipeline stalled until the divider finishes.
- Writes the quotient and remainder into HI/LO.
- On a pipeline flush, abandons an in-flight divide safely by draining the divider before it accepts a new request.

Parameters:
DRAIN_CYCLES, 36, cycles to wait after an aborted divide before a new start is legal (covers the worst-case divider run of DivFree→DivOn→32 iterations→adjust→DivEnd).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
ex_div_req_i  in  1  EX stage holds a DIV/DIVU
ex_div_sign_i  in  1  1 = DIV (signed), 0 = DIVU
ex_opa_i  in  32  dividend (rs)
ex_opb_i  in  32  divisor (rt)
flush_i  in  1  pipeline flush (exception/ERET), squashes EX
stall_req_o  out  1  stall request to pipeline control
div_start_o  out  1  divider start, level held until finish
div_sign_o  out  1  divider sign select
div_dividend_o  out  32  divider dividend
div_divisor_o  out  32  divider divisor
div_finish_i  in  1  divider finish
div_result_i  in  64  divider result {remainder[63:32], quotient[31:0]}
hilo_we_o  out  1  HI/LO write enable
hi_o  out  32  remainder to HI
lo_o  out  32  quotient to LO

Behaviour:
- Reset (rst=0, async): state IDLE; all registered outputs 0, including div_start_o, div_sign_o, operands, hi_o, lo_o, hilo_we_q and the drain counter. Reset mid-operation goes straight to IDLE. The divider is reset by the same system reset.
- States: IDLE, RUN, DONE, DRAIN.
- IDLE:
  - If ex_div_req_i=1 and flush_i=0, then at the next edge: latch ex_opa_i, ex_opb_i and ex_div_sign_i into the div_* registers; set div_start_o=1; go to RUN.
  - Otherwise remain in IDLE.
- RUN:
  - div_start_o, div_sign_o and both operands are held constant. The divider re-reads sign and both operands at the end of the divide to correct signs.
  - If flush_i=1, it takes priority over div_finish_i: div_start_o←0, drain counter←DRAIN_CYCLES, go to DRAIN.
  - Else if div_finish_i=1: hi_o←div_result_i[63:32], lo_o←div_result_i[31:0], hilo_we_q←1, div_start_o←0, go to DONE.
  - Otherwise remain in RUN.
- DONE (exactly 1 cycle):
  - hi_o/lo_o are valid. hilo_we_o=hilo_we_q & ~flush_i, so a flush in this cycle suppresses the write.
  - ex_div_req_i is ignored; it still reflects the completing instruction.
  - Next state IDLE; hilo_we_q←0.
  - div_start_o is low during DONE, so the divider leaves DivEnd. This guarantees start is low for at least 1 cycle between divides.
- DRAIN:
  - Counter decrements by 1 per cycle; when it reaches 1, go to IDLE next edge.
  - div_start_o stays 0. A start raised earlier would be ignored while the divider is still in DivOn.
  - Further flushes have no effect.
- stall_req_o (combinational):
  - 1 when (IDLE & ex_div_req_i & ~flush_i), or RUN & ~flush_i, or (DRAIN & ex_div_req_i & ~flush_i).
  - 0 in DONE, and 0 in any state while flush_i=1.
- Divide by zero: handled by the divider, which returns 64'h0 after a short path. The controller treats it like any other finish: HI=LO=0, write performed.
- Latency: request at cycle t; start high from t+1; finish at about t+36; DONE/write at finish+1; stall released in the DONE cycle.
- There is no timeout. The controller waits in RUN indefinitely for div_finish_i.

Test Plan:
- DIVU 100/7: req with opa=100, opb=7 → stall held until finish; DONE with hilo_we_o=1, hi_o=2, lo_o=14; stall drops in DONE; div_start_o low in DONE.
- DIV signed −7/2: opa=32'hFFFFFFF9, opb=2 → lo_o=32'hFFFFFFFD, hi_o=32'hFFFFFFFF; operands/sign stable on div_* for the whole RUN.
- Divide by zero: opa=5, opb=0 → short run, DONE with hi_o=lo_o=0, hilo_we_o=1.
- Flush 10 cycles into RUN, then a new DIVU 9/3 requested immediately:
  - stall_req_o=0 in the flush cycle; DRAIN lasts 36 cycles with stall_req_o=1 and no start.
  - Start is reissued in IDLE; result hi=0, lo=3.
- Back-to-back DIVU 20/6 then 21/5 → two writes (hi=2, lo=3; then hi=1, lo=4); at least one start-low cycle between runs; no lost or duplicate write.
- Async reset asserted mid-RUN → outputs 0 immediately, state IDLE. Flush asserted in DONE → hilo_we_o=0.
